// File: rtl/fetch_stage.sv
// Instruction-fetch front end: owns the fetch PC, issues requests to a variable-latency
// in-order instruction memory, and queues PC-tagged instructions for decode.
module fetch_stage #(
    parameter int unsigned          DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC  = '0,
    parameter int unsigned          DEPTH      = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  imem_req_o,
    output logic [DATA_WIDTH-1:0] imem_addr_o,
    input  logic                  imem_gnt_i,
    input  logic                  imem_rvalid_i,
    input  logic [DATA_WIDTH-1:0] imem_rdata_i,
    input  logic                  redirect_i,
    input  logic [DATA_WIDTH-1:0] redirect_pc_i,
    output logic                  if_valid_o,
    input  logic                  if_ready_i,
    output logic [DATA_WIDTH-1:0] if_instr_o,
    output logic [DATA_WIDTH-1:0] if_pc_o,
    output logic [DATA_WIDTH-1:0] if_pc_plus4_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        E_EMPTY   = 2'd0,
        E_PENDING = 2'd1,
        E_VALID   = 2'd2
    } entry_e;

    entry_e                r_state [DEPTH];
    logic [DATA_WIDTH-1:0] r_pc    [DEPTH];
    logic [DATA_WIDTH-1:0] r_instr [DEPTH];
    logic [PTR_W-1:0]      r_alloc;
    logic [PTR_W-1:0]      r_fill;
    logic [PTR_W-1:0]      r_head;
    logic [DATA_WIDTH-1:0] r_fetch_pc;
    logic [CNT_W-1:0]      r_outstanding;
    logic [CNT_W-1:0]      r_drop_cnt;

    logic [CNT_W-1:0]      w_used;
    logic                  w_req;
    logic                  w_fire;
    logic                  w_rvalid;
    logic                  w_keep;
    logic                  w_valid;
    logic                  w_pop;

    // Occupancy counts both PENDING and VALID slots.
    always_comb begin
        w_used = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_state[i] != E_EMPTY) begin
                w_used = w_used + CNT_W'(1);
            end
        end
    end

    // Request is gated by reset so it reads 0 while rst is held low.
    assign w_req    = rst && (w_used < DEPTH_C) && (r_outstanding < DEPTH_C) && !redirect_i;
    assign w_fire   = w_req && imem_gnt_i;
    assign w_rvalid = imem_rvalid_i && (r_outstanding != '0);
    assign w_keep   = w_rvalid && (r_drop_cnt == '0);
    assign w_valid  = (r_state[r_head] == E_VALID) && !redirect_i;
    assign w_pop    = w_valid && if_ready_i;

    // Entry states, pointers, PC and counters; redirect overrides all queue activity.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_state[i] <= E_EMPTY;
            end
            r_alloc       <= '0;
            r_fill        <= '0;
            r_head        <= '0;
            r_fetch_pc    <= RESET_PC;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
        end else begin
            r_outstanding <= r_outstanding + CNT_W'(w_fire) - CNT_W'(w_rvalid);
            if (redirect_i) begin
                for (int i = 0; i < DEPTH; i++) begin
                    r_state[i] <= E_EMPTY;
                end
                r_alloc    <= '0;
                r_fill     <= '0;
                r_head     <= '0;
                r_fetch_pc <= redirect_pc_i & ~DATA_WIDTH'(3);
                r_drop_cnt <= r_outstanding + CNT_W'(w_fire) - CNT_W'(w_rvalid);
            end else begin
                if (w_fire) begin
                    r_state[r_alloc] <= E_PENDING;
                    r_alloc          <= r_alloc + PTR_W'(1);
                    r_fetch_pc       <= r_fetch_pc + DATA_WIDTH'(4);
                end
                if (w_rvalid) begin
                    if (r_drop_cnt != '0) begin
                        r_drop_cnt <= r_drop_cnt - CNT_W'(1);
                    end else begin
                        r_state[r_fill] <= E_VALID;
                        r_fill          <= r_fill + PTR_W'(1);
                    end
                end
                if (w_pop) begin
                    r_state[r_head] <= E_EMPTY;
                    r_head          <= r_head + PTR_W'(1);
                end
            end
        end
    end

    // Payload storage needs no reset; entry state qualifies it.
    always_ff @(posedge clk) begin
        if (!redirect_i && w_fire) begin
            r_pc[r_alloc] <= r_fetch_pc;
        end
        if (!redirect_i && w_keep) begin
            r_instr[r_fill] <= imem_rdata_i;
        end
    end

    assign imem_req_o    = w_req;
    assign imem_addr_o   = r_fetch_pc;
    assign if_valid_o    = w_valid;
    assign if_instr_o    = r_instr[r_head];
    assign if_pc_o       = r_pc[r_head];
    assign if_pc_plus4_o = r_pc[r_head] + DATA_WIDTH'(4);

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: a memory model answers grants with random latency, and the
// expected decode stream (sequential PCs from the last reset/redirect) is checked on every pop.
module tb_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        if_valid_o;
    logic        if_ready_i;
    logic [31:0] if_instr_o;
    logic [31:0] if_pc_o;
    logic [31:0] if_pc_plus4_o;

    always #5 clk = ~clk;

    fetch_stage #(.DATA_WIDTH(32), .RESET_PC(RESET_PC), .DEPTH(2)) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .if_valid_o    (if_valid_o),
        .if_ready_i    (if_ready_i),
        .if_instr_o    (if_instr_o),
        .if_pc_o       (if_pc_o),
        .if_pc_plus4_o (if_pc_plus4_o)
    );

    typedef struct { logic [31:0] addr; int due; } mreq_t;
    typedef struct packed { logic [31:0] pc; logic [31:0] instr; } exp_t;

    mreq_t       mq[$];
    exp_t        exp_q[$];
    int          errors = 0;
    int          checks = 0;
    int          delivered = 0;
    int          cyc = 0;
    int          lat_min = 1;
    int          lat_max = 1;
    int          gwait = 0;
    int          gdelay = 0;
    bit          rand_gnt = 0;
    bit          tgt_chk = 0;
    logic [31:0] model_pc;
    logic [31:0] tgt;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Monitor: every accepted instruction must be the next one the model expects.
    always @(negedge clk) begin
        exp_t e;
        if (rst === 1'b1 && if_valid_o && if_ready_i) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pop: got pc %h expected none", if_pc_o);
            end else begin
                e = exp_q.pop_front();
                check("pop_pc", if_pc_o, e.pc);
                check("pop_instr", if_instr_o, e.instr);
                check("pop_pc_plus4", if_pc_plus4_o, e.pc + 32'd4);
            end
            delivered++;
        end
    end

    // One clock cycle: drive at posedge+1, sample at negedge, return at next posedge+1.
    task automatic step(input bit redir, input logic [31:0] rpc, input bit rdy, input bit g, input bit stale);
        cyc++;
        redirect_i    = redir;
        redirect_pc_i = rpc;
        if_ready_i    = rdy;
        imem_gnt_i    = rand_gnt ? (gwait >= gdelay) : g;
        if (stale) begin
            imem_rvalid_i = 1'b1;
            imem_rdata_i  = 32'hDEAD_BEEF;
        end else if (mq.size() > 0 && mq[0].due <= cyc) begin
            imem_rvalid_i = 1'b1;
            imem_rdata_i  = mem_word(mq[0].addr);
            void'(mq.pop_front());
        end else begin
            imem_rvalid_i = 1'b0;
            imem_rdata_i  = $urandom;
        end
        @(negedge clk);
        if (tgt_chk && !redir) check("redirect_addr", imem_addr_o, tgt);
        tgt_chk = 0;
        if (redir) begin
            check("valid_in_redirect", 32'(if_valid_o), 32'h0);
            check("req_in_redirect", 32'(imem_req_o), 32'h0);
            exp_q.delete();
            model_pc = rpc & ~32'h3;
            tgt      = model_pc;
            tgt_chk  = 1;
        end
        if (imem_req_o && imem_gnt_i) begin
            check("fetch_addr", imem_addr_o, model_pc);
            exp_q.push_back('{pc: model_pc, instr: mem_word(model_pc)});
            mq.push_back('{addr: imem_addr_o, due: cyc + int'($urandom_range(lat_max, lat_min))});
            model_pc = model_pc + 32'd4;
            gwait    = 0;
            gdelay   = int'($urandom_range(3, 0));
        end else if (imem_req_o) begin
            gwait++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut(input bit stale_after);
        rst           = 1'b0;
        imem_rvalid_i = 1'b0;
        imem_gnt_i    = 1'b0;
        redirect_i    = 1'b0;
        #1;
        check("rst_req", 32'(imem_req_o), 32'h0);
        check("rst_valid", 32'(if_valid_o), 32'h0);
        check("rst_addr", imem_addr_o, RESET_PC);
        @(posedge clk); #1;
        @(posedge clk); #1;
        exp_q.delete();
        model_pc = RESET_PC;
        tgt_chk  = 0;
        rst      = 1'b1;
        #1;
        check("restart_addr", imem_addr_o, RESET_PC);
        if (stale_after) step(0, 32'h0, 1, 0, 1);
        mq.delete();
    endtask

    initial begin
        int n;
        int start;
        rst           = 1'b0;
        imem_gnt_i    = 1'b1;
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = '0;
        redirect_i    = 1'b0;
        redirect_pc_i = '0;
        if_ready_i    = 1'b1;
        model_pc      = RESET_PC;
        tgt           = '0;
        repeat (3) @(posedge clk);
        #1;
        check("init_req", 32'(imem_req_o), 32'h0);
        check("init_valid", 32'(if_valid_o), 32'h0);
        check("init_addr", imem_addr_o, RESET_PC);
        rst = 1'b1;
        #1;
        check("first_req", 32'(imem_req_o), 32'h1);
        check("first_valid", 32'(if_valid_o), 32'h0);
        check("first_addr", imem_addr_o, RESET_PC);

        // Streaming with single-cycle memory and a ready consumer.
        lat_min = 1; lat_max = 1;
        repeat (12) step(0, 32'h0, 1, 1, 0);

        // Back-pressure from a fresh start: queue fills with pc 0 and 4, then request stops.
        reset_dut(0);
        repeat (6) step(0, 32'h0, 0, 1, 0);
        check("bp_entries", 32'(exp_q.size()), 32'd2);
        check("bp_req", 32'(imem_req_o), 32'h0);
        check("bp_valid", 32'(if_valid_o), 32'h1);
        check("bp_head_pc", if_pc_o, RESET_PC);
        repeat (8) step(0, 32'h0, 1, 1, 0);

        // Redirect with two responses in flight.
        lat_min = 3; lat_max = 3;
        n = 0;
        while (mq.size() != 2 && n < 20) begin
            step(0, 32'h0, 1, 1, 0);
            n++;
        end
        check("two_in_flight", 32'(mq.size()), 32'd2);
        step(1, 32'h100, 1, 1, 0);
        repeat (14) step(0, 32'h0, 1, 1, 0);

        // Redirect coinciding with a response and an unaligned target.
        lat_min = 1; lat_max = 2;
        n = 0;
        while (!(mq.size() > 0 && mq[0].due <= cyc + 1) && n < 20) begin
            step(0, 32'h0, 1, 1, 0);
            n++;
        end
        check("rvalid_at_redirect", 32'(mq.size() > 0 && mq[0].due <= cyc + 1), 32'h1);
        step(1, 32'h203, 1, 1, 0);
        repeat (12) step(0, 32'h0, 1, 1, 0);

        // Random grant delay, latency, ready and redirects (some near the 2^32 wrap).
        rand_gnt = 1; lat_min = 1; lat_max = 4;
        start = delivered;
        n = 0;
        while (delivered - start < 1000 && n < 30000) begin
            logic [31:0] rpc;
            bit redir;
            redir = ($urandom_range(59, 0) == 0);
            rpc   = ($urandom_range(4, 0) == 0) ? 32'hFFFF_FFF4 : ($urandom & 32'h0000_FFFF);
            step(redir, rpc, ($urandom_range(3, 0) != 0), 0, 0);
            n++;
        end
        check("random_delivered", 32'(delivered - start >= 1000), 32'h1);

        // Reset mid-stream with responses still outstanding in the memory.
        rand_gnt = 0;
        lat_min = 3; lat_max = 3;
        repeat (2) step(0, 32'h0, 1, 1, 0);
        reset_dut(1);
        lat_min = 1; lat_max = 3;
        repeat (15) step(0, 32'h0, 1, 1, 0);

        // Drain: stop granting and let everything return and be consumed.
        repeat (20) step(0, 32'h0, 1, 0, 0);
        check("drain_empty", 32'(exp_q.size()), 32'h0);
        check("mem_idle", 32'(mq.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
